// File: rtl/risc_pkg.sv
// Shared encodings for the pin-driven program loader.
// Command modes, loader states and status bit positions.
package risc_pkg;

  localparam logic [1:0] MODE_DATA    = 2'b00;
  localparam logic [1:0] MODE_SETADDR = 2'b01;
  localparam logic [1:0] MODE_RUN     = 2'b10;
  localparam logic [1:0] MODE_HALT    = 2'b11;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int STATUS_RUN  = 7;
  localparam int STATUS_WRAP = 6;
  localparam int STATUS_PART = 5;
  localparam int STATUS_RDAT = 4;

endpackage

// File: rtl/risc_prog_loader_if.sv
// Instruction-memory write bus driven by the program loader.
// master = loader side, slave = memory side.
interface risc_prog_loader_if #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 7
);
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    input mem_we,
    input mem_addr,
    input mem_wdata
  );
endinterface

// File: rtl/risc_pin_sync.sv
// Pin synchroniser: flop chain on {strobe,mode,data}, then a
// registered strobe rising-edge pulse with the matching payload.
module risc_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobe,
  input  logic [1:0] mode,
  input  logic [7:0] data,
  output logic       rise,
  output logic [1:0] mode_s,
  output logic [7:0] data_s
);

  logic [STAGES-1:0][10:0] chain;
  logic [10:0]             tail;
  logic                    prev;

  assign tail = chain[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= '0;
      prev   <= 1'b0;
      rise   <= 1'b0;
      mode_s <= 2'b00;
      data_s <= 8'h00;
    end else begin
      chain  <= {chain[STAGES-2:0], {strobe, mode, data}};
      prev   <= tail[10];
      rise   <= tail[10] & ~prev;
      mode_s <= tail[9:8];
      data_s <= tail[7:0];
    end
  end

endmodule

// File: rtl/risc_prog_loader.sv
// Program loader: assembles pin bytes into instruction words,
// writes them to instruction memory and gates the core run.
module risc_prog_loader
  import risc_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               pin_strobe,
  input  logic [1:0]         pin_mode,
  input  logic [7:0]         pin_data,
  risc_prog_loader_if.master mem,
  output logic               cpu_run,
  output logic [7:0]         status
);

  localparam int         BYTES = INSTR_W / 8;
  localparam logic [3:0] LAST  = 4'(BYTES - 1);

  logic               rise;
  logic [1:0]         s_mode;
  logic [7:0]         s_data;
  state_t             state;
  state_t             state_nx;
  logic [ADDR_W-1:0]  addr;
  logic [3:0]         byte_idx;
  logic [INSTR_W-1:0] word;
  logic [INSTR_W-1:0] word_nx;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               wrapped;
  logic               err_partial;
  logic               err_run_data;
  logic               pend;
  logic [1:0]         pend_mode;
  logic [7:0]         pend_data;
  logic               cmd_v;
  logic [1:0]         cmd_mode;
  logic [7:0]         cmd_data;
  logic               is_data;
  logic               is_set;
  logic               is_run;
  logic               is_halt;
  logic               partial;

  risc_pin_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (pin_strobe),
    .mode   (pin_mode),
    .data   (pin_data),
    .rise   (rise),
    .mode_s (s_mode),
    .data_s (s_data)
  );

  // An edge landing in COMMIT is parked in pend and replayed next cycle.
  assign cmd_v    = (state != ST_COMMIT) &&
                    (pend || (rise && ena));
  assign cmd_mode = pend ? pend_mode : s_mode;
  assign cmd_data = pend ? pend_data : s_data;
  assign is_data  = cmd_v && (cmd_mode == MODE_DATA);
  assign is_set   = cmd_v && (cmd_mode == MODE_SETADDR);
  assign is_run   = cmd_v && (cmd_mode == MODE_RUN);
  assign is_halt  = cmd_v && (cmd_mode == MODE_HALT);
  assign partial  = (byte_idx != 4'd0);

  always_comb begin
    word_nx = word;
    for (int i = 0; i < BYTES; i++) begin
      if (byte_idx == 4'(i)) word_nx[i*8 +: 8] = cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_LOAD: begin
        unique case (1'b1)
          is_halt: state_nx = ST_LOAD;
          is_run:  state_nx = ST_RUN;
          is_data: if (byte_idx == LAST) state_nx = ST_COMMIT;
          default: state_nx = ST_LOAD;
        endcase
      end
      ST_COMMIT: state_nx = ST_LOAD;
      ST_RUN:    if (is_halt) state_nx = ST_LOAD;
      default:   state_nx = ST_LOAD;
    endcase
  end

  always_comb begin
    mem.mem_we    = (state == ST_COMMIT);
    mem.mem_addr  = wr_addr;
    mem.mem_wdata = wr_data;
    cpu_run       = (state == ST_RUN);
    status        = 8'h00;
    status[STATUS_RUN]  = (state == ST_RUN);
    status[STATUS_WRAP] = wrapped;
    status[STATUS_PART] = err_partial;
    status[STATUS_RDAT] = err_run_data;
    status[3:0]         = byte_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= '0;
      byte_idx     <= 4'd0;
      word         <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wrapped      <= 1'b0;
      err_partial  <= 1'b0;
      err_run_data <= 1'b0;
      pend         <= 1'b0;
      pend_mode    <= 2'b00;
      pend_data    <= 8'h00;
    end else begin
      pend <= (state == ST_COMMIT) && rise && ena;
      if ((state == ST_COMMIT) && rise) begin
        pend_mode <= s_mode;
        pend_data <= s_data;
      end
      if (state == ST_COMMIT) begin
        addr <= addr + ADDR_W'(1);
        if (&addr) wrapped <= 1'b1;
      end
      if (state == ST_LOAD) begin
        if (is_data) begin
          word <= word_nx;
          if (byte_idx == LAST) begin
            byte_idx <= 4'd0;
            wr_addr  <= addr;
            wr_data  <= word_nx;
          end else begin
            byte_idx <= byte_idx + 4'd1;
          end
        end
        if (is_set) begin
          addr     <= ADDR_W'(cmd_data);
          byte_idx <= 4'd0;
          if (partial) err_partial <= 1'b1;
        end
        if (is_run) begin
          byte_idx <= 4'd0;
          if (partial) err_partial <= 1'b1;
        end
      end
      if ((state == ST_RUN) && (is_data || is_set))
        err_run_data <= 1'b1;
      if (is_halt) begin
        byte_idx     <= 4'd0;
        wrapped      <= 1'b0;
        err_partial  <= 1'b0;
        err_run_data <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_risc_prog_loader.sv
// Scoreboard bench for risc_prog_loader (16-bit and 32-bit words).
// Directed commands push expected writes; monitors pop and compare.
module tb_risc_prog_loader;
  import risc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       ena32;
  logic       strobe16, strobe32;
  logic [1:0] mode16, mode32;
  logic [7:0] data16, data32;
  logic       run16, run32;
  logic [7:0] st16, st32;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t q16[$];
  wr_t q32[$];

  always #5 clk = ~clk;

  risc_prog_loader_if #(.INSTR_W(16), .ADDR_W(7)) mif16 ();
  risc_prog_loader_if #(.INSTR_W(32), .ADDR_W(7)) mif32 ();

  risc_prog_loader #(
    .INSTR_W(16), .ADDR_W(7), .SYNC_STAGES(2)
  ) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .pin_strobe (strobe16),
    .pin_mode   (mode16),
    .pin_data   (data16),
    .mem        (mif16),
    .cpu_run    (run16),
    .status     (st16)
  );

  risc_prog_loader #(
    .INSTR_W(32), .ADDR_W(7), .SYNC_STAGES(2)
  ) dut32 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena32),
    .pin_strobe (strobe32),
    .pin_mode   (mode32),
    .pin_data   (data32),
    .mem        (mif32),
    .cpu_run    (run32),
    .status     (st32)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mif16.mem_we === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr16_extra: got addr %h data %h expected no write",
                 mif16.mem_addr, mif16.mem_wdata);
      end else begin
        e = q16.pop_front();
        chk("wr16_addr", 32'(mif16.mem_addr), 32'(e.a));
        chk("wr16_data", 32'(mif16.mem_wdata), e.d);
        chk("wr16_not_run", 32'(run16), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (mif32.mem_we === 1'b1) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr32_extra: got addr %h data %h expected no write",
                 mif32.mem_addr, mif32.mem_wdata);
      end else begin
        e = q32.pop_front();
        chk("wr32_addr", 32'(mif32.mem_addr), 32'(e.a));
        chk("wr32_data", mif32.mem_wdata, e.d);
      end
    end
  end

  task automatic push16(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    q16.push_back(e);
  endtask

  task automatic push32(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    q32.push_back(e);
  endtask

  task automatic send(input bit big,
                      input logic [1:0] m,
                      input logic [7:0] d);
    @(negedge clk);
    if (big) begin
      mode32 = m; data32 = d; strobe32 = 1'b1;
    end else begin
      mode16 = m; data16 = d; strobe16 = 1'b1;
    end
    repeat (4) @(negedge clk);
    if (big) strobe32 = 1'b0;
    else     strobe16 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_idle16(input string tag);
    chk({tag, "_we"},    32'(mif16.mem_we),    32'd0);
    chk({tag, "_addr"},  32'(mif16.mem_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(mif16.mem_wdata), 32'd0);
    chk({tag, "_run"},   32'(run16),           32'd0);
    chk({tag, "_stat"},  32'(st16),            32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100us");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; ena32 = 1'b1;
    strobe16 = 1'b0; mode16 = MODE_DATA; data16 = 8'h00;
    strobe32 = 1'b0; mode32 = MODE_DATA; data32 = 8'h00;
    repeat (3) @(negedge clk);
    chk_idle16("reset");
    chk("reset_stat32", 32'(st32), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic word assembly, then address 1
    push16(8'h00, 32'h1234);
    send(0, MODE_DATA, 8'h34);
    chk("t1_idx1", 32'(st16), 32'h01);
    send(0, MODE_DATA, 8'h12);
    chk("t1_stat", 32'(st16), 32'h00);
    push16(8'h01, 32'h5678);
    send(0, MODE_DATA, 8'h78);
    send(0, MODE_DATA, 8'h56);

    // wrap from 0x7F to 0x00
    send(0, MODE_SETADDR, 8'h7F);
    push16(8'h7F, 32'hBBAA);
    send(0, MODE_DATA, 8'hAA);
    send(0, MODE_DATA, 8'hBB);
    push16(8'h00, 32'hDDCC);
    send(0, MODE_DATA, 8'hCC);
    send(0, MODE_DATA, 8'hDD);
    chk("t2_wrapped", 32'(st16), 32'h40);
    chk("t2_hold_addr", 32'(mif16.mem_addr), 32'h00);
    chk("t2_hold_data", 32'(mif16.mem_wdata), 32'hDDCC);

    // partial word then RUN; cpu_run rises at E+1
    send(0, MODE_DATA, 8'hAA);
    chk("t3_partial_idx", 32'(st16), 32'h41);
    @(negedge clk);
    mode16 = MODE_RUN; data16 = 8'h00; strobe16 = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("t3_run_at_E", 32'(run16), 32'd0);
    @(posedge clk);
    #1 chk("t3_run_at_E1", 32'(run16), 32'd1);
    repeat (2) @(negedge clk);
    strobe16 = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_stat", 32'(st16), 32'hE0);

    // data while running, then HALT
    send(0, MODE_DATA, 8'h55);
    chk("t4_run_data", 32'(st16), 32'hF0);
    send(0, MODE_RUN, 8'h00);
    chk("t4_run_run", 32'(st16), 32'hF0);
    send(0, MODE_HALT, 8'h00);
    chk("t4_halt_stat", 32'(st16), 32'h00);
    chk("t4_halt_run", 32'(run16), 32'd0);
    push16(8'h01, 32'h2211);
    send(0, MODE_DATA, 8'h11);
    send(0, MODE_DATA, 8'h22);

    // reset lands before the final byte can commit
    send(0, MODE_DATA, 8'h99);
    @(negedge clk);
    mode16 = MODE_DATA; data16 = 8'h88; strobe16 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    strobe16 = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle16("t5_rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_idle16("t5_post");
    push16(8'h00, 32'h0201);
    send(0, MODE_DATA, 8'h01);
    send(0, MODE_DATA, 8'h02);

    // ena low: every edge ignored
    ena = 1'b0;
    send(0, MODE_DATA, 8'h10);
    send(0, MODE_SETADDR, 8'h05);
    send(0, MODE_RUN, 8'h00);
    chk("t6_ena_stat", 32'(st16), 32'h00);
    chk("t6_ena_run", 32'(run16), 32'd0);
    ena = 1'b1;
    push16(8'h01, 32'h0403);
    send(0, MODE_DATA, 8'h03);
    send(0, MODE_DATA, 8'h04);
    chk("t6_addr", 32'(mif16.mem_addr), 32'h01);
    chk("t6_data", 32'(mif16.mem_wdata), 32'h0403);

    // 32-bit build: four bytes -> one write
    push32(8'h00, 32'h44332211);
    send(1, MODE_DATA, 8'h11);
    send(1, MODE_DATA, 8'h22);
    chk("t6_w32_idx", 32'(st32), 32'h02);
    send(1, MODE_DATA, 8'h33);
    send(1, MODE_DATA, 8'h44);
    chk("t6_w32_stat", 32'(st32), 32'h00);

    repeat (4) @(negedge clk);
    chk("q16_empty", 32'(q16.size()), 32'd0);
    chk("q32_empty", 32'(q32.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
